// File: rtl/sim_stop_monitor.sv
// Quiescence and watchdog monitor: flags "machine stopped" once the watched state
// has been stable for STOP_THRESH cycles with every activity channel idle.
module sim_stop_monitor #(
   parameter int STATE_W     = 3,
   parameter int BUSY_N      = 2,
   parameter int CNT_W       = 12,
   parameter int STOP_THRESH = 4095,
   parameter int TMO_W       = 32,
   parameter int TIMEOUT     = 0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic               clear,
   input  logic [STATE_W-1:0] state_in,
   input  logic [BUSY_N-1:0]  busy_in,
   output logic               machine_is_stop,
   output logic               stop_pulse,
   output logic [CNT_W-1:0]   stable_count,
   output logic [TMO_W-1:0]   cycle_count,
   output logic               timeout
);

   if (STOP_THRESH < 1 || longint'(STOP_THRESH) >= (longint'(1) << CNT_W)) begin : g_bad_thresh
      $error("sim_stop_monitor: STOP_THRESH must lie in 1 .. 2**CNT_W-1");
   end
   if (TIMEOUT < 0 || (TMO_W < 63 && longint'(TIMEOUT) >= (longint'(1) << TMO_W))) begin : g_bad_timeout
      $error("sim_stop_monitor: TIMEOUT must lie in 0 .. 2**TMO_W-1");
   end

   localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(STOP_THRESH);
   localparam bit               TMO_ON     = (TIMEOUT != 0);
   localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP, ST_TMO} fsm_t;

   fsm_t               fsm_reg, fsm_next;
   logic [STATE_W-1:0] last_state_reg;
   logic               sample_valid_reg;
   logic [CNT_W-1:0]   stable_count_reg, stable_count_next;
   logic [TMO_W-1:0]   cycle_count_reg, cycle_count_next;
   logic               stop_pulse_reg, stop_pulse_next;
   logic [STATE_W-1:0] state_diff;
   logic               stop_cond;

   for (genvar gi = 0; gi < STATE_W; gi++) begin : g_diff
      assign state_diff[gi] = state_in[gi] ^ last_state_reg[gi];
   end

   assign stop_cond = (stable_count_reg == THRESH_C) && (busy_in == '0);

   always_comb begin
      stable_count_next = '0;
      cycle_count_next  = cycle_count_reg;
      fsm_next          = fsm_reg;
      stop_pulse_next   = 1'b0;

      // The first sample after reset/clear has nothing valid to compare against.
      if (sample_valid_reg && (state_diff == '0)) begin
         if (stable_count_reg >= THRESH_C)
            stable_count_next = THRESH_C;
         else
            stable_count_next = stable_count_reg + 1'b1;
      end

      if ((fsm_reg == ST_IDLE || fsm_reg == ST_RUN) && (cycle_count_reg != '1))
         cycle_count_next = cycle_count_reg + 1'b1;

      case (fsm_reg)
         ST_IDLE: fsm_next = ST_RUN;
         ST_RUN: begin
            if (stop_cond) begin
               fsm_next        = ST_STOP;
               stop_pulse_next = 1'b1;
            end else if (TMO_ON && (cycle_count_reg >= TMO_LAST_C)) begin
               fsm_next = ST_TMO;
            end
         end
         ST_STOP: if (!stop_cond) fsm_next = ST_RUN;
         default: fsm_next = ST_TMO;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fsm_reg          <= ST_IDLE;
         last_state_reg   <= '0;
         sample_valid_reg <= 1'b0;
         stable_count_reg <= '0;
         cycle_count_reg  <= '0;
         stop_pulse_reg   <= 1'b0;
      end else if (clear) begin
         fsm_reg          <= ST_IDLE;
         last_state_reg   <= '0;
         sample_valid_reg <= 1'b0;
         stable_count_reg <= '0;
         cycle_count_reg  <= '0;
         stop_pulse_reg   <= 1'b0;
      end else if (en) begin
         fsm_reg          <= fsm_next;
         last_state_reg   <= state_in;
         sample_valid_reg <= 1'b1;
         stable_count_reg <= stable_count_next;
         cycle_count_reg  <= cycle_count_next;
         stop_pulse_reg   <= stop_pulse_next;
      end else begin
         stop_pulse_reg   <= 1'b0;
      end
   end

   assign machine_is_stop = stop_cond && (fsm_reg != ST_TMO);
   assign stop_pulse      = stop_pulse_reg && en;
   assign stable_count    = stable_count_reg;
   assign cycle_count     = cycle_count_reg;
   assign timeout         = (fsm_reg == ST_TMO);

endmodule

// File: tb/tb_sim_stop_monitor.sv
// Bench for sim_stop_monitor: cycle-level reference model plus directed literal checks.
module tb_sim_stop_monitor;

   localparam int STH = 7;
   localparam int TMO = 20;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        en = 1'b1;
   logic        clear = 1'b0;
   logic [2:0]  state_in = 3'd5;
   logic [1:0]  busy_in = 2'b00;
   logic        machine_is_stop, stop_pulse, timeout;
   logic [11:0] stable_count;
   logic [31:0] cycle_count;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   sim_stop_monitor #(
      .STATE_W(3), .BUSY_N(2), .CNT_W(12), .STOP_THRESH(STH), .TMO_W(32), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .resetn(resetn), .en(en), .clear(clear),
      .state_in(state_in), .busy_in(busy_in),
      .machine_is_stop(machine_is_stop), .stop_pulse(stop_pulse),
      .stable_count(stable_count), .cycle_count(cycle_count), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 running, 2 stopped, 3 timed out.
   int         m_phase = 0;
   bit         m_valid = 0;
   logic [2:0] m_last = '0;
   int         m_count = 0;
   longint     m_cc = 0;
   bit         m_pulse = 0;
   bit         m_cond;
   int         m_cnt_new;

   always @(posedge clk or negedge resetn) begin
      if (!resetn || clear) begin
         m_phase = 0; m_valid = 0; m_last = '0; m_count = 0; m_cc = 0; m_pulse = 0;
      end else if (en) begin
         m_cond = (m_count == STH) && (busy_in == 2'b00);
         if (m_valid && state_in == m_last)
            m_cnt_new = (m_count + 1 > STH) ? STH : m_count + 1;
         else
            m_cnt_new = 0;
         if (m_phase <= 1 && m_cc < 64'hFFFF_FFFF) m_cc = m_cc + 1;
         m_pulse = 0;
         if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1) begin
            if (m_cond) begin m_phase = 2; m_pulse = 1; end
            else if (m_cc - 1 >= TMO - 1) m_phase = 3;
         end else if (m_phase == 2 && !m_cond) m_phase = 1;
         m_count = m_cnt_new;
         m_last = state_in;
         m_valid = 1;
      end else begin
         m_pulse = 0;
      end
   end

   task automatic check(input string name, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_stop", machine_is_stop,
               (m_count == STH) && (busy_in == 2'b00) && (m_phase != 3));
         check("model_pulse", stop_pulse, m_pulse && en);
         check("model_count", stable_count, m_count);
         check("model_cycles", cycle_count, m_cc);
         check("model_timeout", timeout, m_phase == 3);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_stop", machine_is_stop, 0);
      check("rst_pulse", stop_pulse, 0);
      check("rst_count", stable_count, 0);
      check("rst_cycles", cycle_count, 0);
      check("rst_timeout", timeout, 0);
      resetn = 1'b1;
      chk_en = 1'b1;

      // Constant state from the first sample: counts 0,0,1..7
      for (int i = 1; i <= 8; i++) begin
         step(1);
         check("ramp_count", stable_count, (i <= 1) ? 0 : i - 1);
      end
      check("ramp_stop", machine_is_stop, 1);
      check("ramp_nopulse", stop_pulse, 0);
      step(1);
      check("first_pulse", stop_pulse, 1);
      check("first_cycles", cycle_count, 9);
      step(1);
      check("pulse_once", stop_pulse, 0);

      // Busy channel masks stop, count holds saturated
      busy_in = 2'b01; #1;
      check("busy_stop", machine_is_stop, 0);
      step(1);
      check("busy_count", stable_count, 7);
      check("busy_cycles", cycle_count, 9);
      busy_in = 2'b00; #1;
      check("unbusy_stop", machine_is_stop, 1);
      step(1);
      check("rearm_pulse", stop_pulse, 1);
      step(1);
      check("rearm_once", stop_pulse, 0);

      // State change while stopped, then re-stabilise on 6
      state_in = 3'd6;
      step(1);
      check("toggle_count", stable_count, 0);
      check("toggle_stop", machine_is_stop, 0);
      step(7);
      check("restab_count", stable_count, 7);
      step(1);
      check("second_pulse", stop_pulse, 1);
      check("second_cycles", cycle_count, 17);

      // Enable gating
      clear = 1'b1; step(1); clear = 1'b0;
      check("clr_count", stable_count, 0);
      check("clr_cycles", cycle_count, 0);
      state_in = 3'd5;
      step(5);
      check("en_pre_count", stable_count, 4);
      en = 1'b0;
      step(10);
      check("en_hold_count", stable_count, 4);
      check("en_hold_cycles", cycle_count, 5);
      en = 1'b1;
      step(1);
      check("en_resume_count", stable_count, 5);
      check("en_resume_cycles", cycle_count, 6);

      // Asynchronous reset mid-count
      clear = 1'b1; step(1); clear = 1'b0;
      step(4);
      check("pre_rst_count", stable_count, 3);
      #2 resetn = 1'b0;
      #1;
      check("arst_count", stable_count, 0);
      check("arst_cycles", cycle_count, 0);
      check("arst_stop", machine_is_stop, 0);
      step(2);
      resetn = 1'b1;
      step(1);
      check("post_rst_first", stable_count, 0);
      step(1);
      check("post_rst_second", stable_count, 1);

      // Watchdog: state toggles every cycle
      clear = 1'b1; step(1); clear = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         state_in = (i % 2 == 1) ? 3'd1 : 3'd2;
         step(1);
         if (i == 19) check("tmo_not_yet", timeout, 0);
      end
      check("tmo_flag", timeout, 1);
      check("tmo_cycles", cycle_count, 20);
      state_in = 3'd3;
      step(12);
      check("tmo_count_sat", stable_count, 7);
      check("tmo_no_stop", machine_is_stop, 0);
      check("tmo_sticky", timeout, 1);
      check("tmo_frozen", cycle_count, 20);
      clear = 1'b1; step(1); clear = 1'b0;
      check("tmo_clr_flag", timeout, 0);
      check("tmo_clr_cycles", cycle_count, 0);
      check("tmo_clr_count", stable_count, 0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
